// File: rtl/gray_enc_arbiter.sv
// gray_enc_arbiter
//   Round-robin arbiter in front of one registered binary-to-Gray encode
//   stage. NREQ requesters offer WIDTH-bit words over valid/ready; the
//   winner's word is encoded and captured into a single-entry output
//   register together with the original word and the requester index.
//
//   state | meaning
//   EMPTY | output register holds nothing; any valid request is accepted
//   FULL  | output register holds a result; refilled only when popped
//
// Ports
//   clock      system clock, rising edge
//   reset      asynchronous, active-low reset
//   req_valid  per-requester valid
//   req_data   requester i's word in [i*WIDTH +: WIDTH]
//   req_ready  one-hot (or zero) accept strobe, combinational
//   out_valid  output register holds a result
//   out_ready  consumer pops the output this cycle
//   out_gray   Gray code of the accepted word
//   out_bin    accepted binary word
//   out_id     index of the requester that supplied the word
//   busy       output held because the consumer is stalling
module gray_enc_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4,
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_gray,
  output logic [WIDTH-1:0]      out_bin,
  output logic [IDW-1:0]        out_id,
  output logic                  busy
);

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [IDW-1:0]   last_grant;
  logic [IDW-1:0]   winner;
  logic             found;
  logic             accept;
  logic             grant;
  logic [WIDTH-1:0] win_data;

  // Search starts just after the previous winner and wraps, so the first
  // valid requester found is the round-robin winner.
  always_comb begin : arbitrate
    int             idx;
    logic [IDW-1:0] idx_l;
    winner = last_grant;
    found  = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(last_grant) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      idx_l = IDW'(idx);
      if (!found && req_valid[idx_l]) begin
        found  = 1'b1;
        winner = idx_l;
      end
    end
  end

  always_comb begin : select_data
    win_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (winner == IDW'(i)) win_data = req_data[i*WIDTH +: WIDTH];
    end
  end

  assign accept = (state == EMPTY) | out_ready;
  // Gating with reset keeps req_ready low while reset is held, even though
  // the EMPTY state would otherwise accept.
  assign grant  = accept & found & reset;

  always_comb begin : ready_decode
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant && (winner == IDW'(i))) req_ready[i] = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= EMPTY;
    else        state <= state_next;
  end

  always_comb begin : next_state
    state_next = state;
    case (state)
      EMPTY:   if (grant) state_next = FULL;
      FULL:    if (out_ready && !grant) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_grant <= IDW'(NREQ - 1);
      out_gray   <= '0;
      out_bin    <= '0;
      out_id     <= '0;
    end else if (grant) begin
      last_grant <= winner;
      out_gray   <= win_data ^ (win_data >> 1);
      out_bin    <= win_data;
      out_id     <= winner;
    end
  end

  assign out_valid = (state == FULL);
  assign busy      = out_valid & ~out_ready;

endmodule
